// File: rtl/bus_merge_arb.sv
// bus_merge_arb: merges NUM_CH valid/ready channels onto one registered
// valid/ready output. Arbitration is round-robin or fixed-priority, chosen at
// run time by prio_mode. A granted channel may keep the grant for up to
// BURST_LEN consecutive beats while it stays valid.
module bus_merge_arb #(
    parameter  int NUM_CH    = 4,
    parameter  int WIDTH     = 2,
    parameter  int BURST_LEN = 1,
    localparam int SRC_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    prio_mode,
    output logic [WIDTH-1:0]        out_data,
    output logic [SRC_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready
);

    // Burst counter holds up to 254 (BURST_LEN-1 with BURST_LEN <= 255).
    localparam int CNT_W = 8;

    logic [NUM_CH-1:0][WIDTH-1:0] ch_data;
    logic [SRC_W-1:0]             last_grant;
    logic [CNT_W-1:0]             burst_cnt;
    logic                         locked;

    logic                         can_load;
    logic                         grant_vld;
    logic [SRC_W-1:0]             grant;
    logic [SRC_W-1:0]             rr_idx;
    logic                         cont_lock;
    logic                         accept;
    logic [CNT_W-1:0]             nxt_cnt;

    assign ch_data  = in_data;
    assign can_load = !out_valid || out_ready;
    assign accept   = grant_vld && can_load;
    assign nxt_cnt  = cont_lock ? (burst_cnt - 1'b1) : CNT_W'(BURST_LEN - 1);

    // Pick at most one channel: a live lock wins, else priority or round-robin.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        rr_idx    = '0;
        cont_lock = 1'b0;
        if (locked && in_valid[last_grant]) begin
            grant_vld = 1'b1;
            grant     = last_grant;
            cont_lock = 1'b1;
        end else if (prio_mode) begin
            // Descending scan so the lowest requesting index is the final winner.
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant     = SRC_W'(i);
                end
            end
        end else begin
            // Descending offset so the channel nearest after last_grant wins.
            for (int k = NUM_CH; k >= 1; k--) begin
                rr_idx = SRC_W'((int'(last_grant) + k) % NUM_CH);
                if (in_valid[rr_idx]) begin
                    grant_vld = 1'b1;
                    grant     = rr_idx;
                end
            end
        end
    end

    // Ready only to the granted channel; forced low while reset is asserted.
    always_comb begin
        in_ready = '0;
        if (rst_n && accept) in_ready[grant] = 1'b1;
    end

    // Output register plus arbitration state (last grant, burst lock).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= '0;
            last_grant <= SRC_W'(NUM_CH - 1);
            burst_cnt  <= '0;
            locked     <= 1'b0;
        end else begin
            if (accept) begin
                out_data   <= ch_data[grant];
                out_src    <= grant;
                out_valid  <= 1'b1;
                last_grant <= grant;
                burst_cnt  <= nxt_cnt;
                locked     <= (nxt_cnt != '0);
            end else begin
                if (out_ready) out_valid <= 1'b0;
                // Owner dropping valid ends the lock even under backpressure.
                if (locked && !in_valid[last_grant]) locked <= 1'b0;
            end
        end
    end

endmodule
